// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit words and writes them sequentially to instruction memory.
// Latency: accept at edge N, write strobe during cycle N+2. One word every 3 cycles. ready_o is low outside IDLE, and requests stall while FULL.
module instr_encoder #(
   parameter int          DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [2:0]              kind_i,
   input  logic [4:0]              rs_i,
   input  logic [4:0]              rt_i,
   input  logic [4:0]              rd_i,
   input  logic [4:0]              shamt_i,
   input  logic [5:0]              funct_i,
   input  logic [15:0]             imm_i,
   input  logic [25:0]             target_i,
   output logic                    imem_we_o,
   output logic [31:0]             imem_addr_o,
   output logic [31:0]             imem_data_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001001;
   localparam logic [5:0] OP_LW   = 6'b101100;
   localparam logic [5:0] OP_SW   = 6'b100100;
   localparam logic [5:0] OP_BEQ  = 6'b000110;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000111;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

   state_t         state;
   logic [2:0]     kind_q;
   logic [4:0]     rs_q;
   logic [4:0]     rt_q;
   logic [4:0]     rd_q;
   logic [4:0]     shamt_q;
   logic [5:0]     funct_q;
   logic [15:0]    imm_q;
   logic [25:0]    target_q;
   logic [31:0]    word;
   logic [31:0]    data_r;
   logic [CW-1:0]  count_r;
   logic           we_r;
   logic           ready_r;
   logic           full_r;

   always_comb begin
      word = '0;
      case (kind_q)
         3'd0:    word = {OP_R, rs_q, rt_q, rd_q, shamt_q, funct_q};
         3'd1:    word = {OP_ADDI, rs_q, rt_q, imm_q};
         3'd2:    word = {OP_LW, rs_q, rt_q, imm_q};
         3'd3:    word = {OP_SW, rs_q, rt_q, imm_q};
         3'd4:    word = {OP_BEQ, rs_q, rt_q, imm_q};
         3'd5:    word = {OP_BNE, rs_q, rt_q, imm_q};
         3'd6:    word = {OP_J, target_q};
         default: word = {OP_JAL, target_q};
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         kind_q   <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         shamt_q  <= '0;
         funct_q  <= '0;
         imm_q    <= '0;
         target_q <= '0;
         data_r   <= '0;
         count_r  <= '0;
         we_r     <= 1'b0;
         ready_r  <= 1'b1;
         full_r   <= 1'b0;
      end else if (clear_i) begin
         state   <= IDLE;
         count_r <= '0;
         we_r    <= 1'b0;
         ready_r <= 1'b1;
         full_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  kind_q   <= kind_i;
                  rs_q     <= rs_i;
                  rt_q     <= rt_i;
                  rd_q     <= rd_i;
                  shamt_q  <= shamt_i;
                  funct_q  <= funct_i;
                  imm_q    <= imm_i;
                  target_q <= target_i;
                  ready_r  <= 1'b0;
                  state    <= ENC;
               end
            end
            ENC: begin
               data_r <= word;
               we_r   <= 1'b1;
               state  <= WR;
            end
            WR: begin
               we_r    <= 1'b0;
               count_r <= count_r + 1'b1;
               if (count_r == CW'(DEPTH - 1)) begin
                  full_r <= 1'b1;
                  state  <= FULL;
               end else begin
                  ready_r <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // A clear landing in the WR cycle must kill the strobe in that same cycle.
   assign imem_we_o   = we_r & ~clear_i;
   assign imem_addr_o = BASE_ADDR + (32'(count_r) << 2);
   assign imem_data_o = data_r;
   assign count_o     = count_r;
   assign full_o      = full_r;
   assign ready_o     = ready_r;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential instruction encoder and program loader, the counterpart of the control decoder. It accepts instruction kinds and operand fields over a valid/ready handshake and packs them into 32-bit words using the decoder's opcode set. It writes the words sequentially into the instruction-memory write port. Benches and boot logic use it to build programs that the fetch/decode path later executes.

Parameters:
DEPTH, 32, instruction-memory capacity in words (power of 2, at least 2)
BASE_ADDR, 32'h0000_0000, byte address of the first word (word-aligned)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous restart: abort the current op, pointer to 0
valid_i  in  1  request valid
ready_o  out  1  encoder can accept a request
kind_i  in  3  0=R 1=ADDI 2=LW 3=SW 4=BEQ 5=BNE 6=J 7=JAL
rs_i, rt_i, rd_i, shamt_i  in  5 each  register/shift fields
funct_i  in  6  R-type funct
imm_i  in  16  I-type immediate
target_i  in  26  J-type target
imem_we_o  out  1  one-cycle write strobe
imem_addr_o  out  32  byte address = BASE_ADDR + 4*ptr
imem_data_o  out  32  encoded word
count_o  out  $clog2(DEPTH)+1  words written since reset/clear
full_o  out  1  count_o == DEPTH

Behaviour:
- Reset (rst_i low, async): state IDLE; ptr=0; count_o=0; full_o=0; imem_we_o=0; imem_addr_o=BASE_ADDR; imem_data_o=0. ready_o=1 once reset is released.
- FSM states: IDLE, ENC, WR, FULL.
- IDLE: ready_o=1. On valid_i&ready_o, capture all input fields, then go to ENC.
- ENC: ready_o=0. Register the encoded word, then go to WR.
- WR: ready_o=0. imem_we_o=1 for exactly this cycle, with imem_addr_o and imem_data_o stable. At the end of the cycle, ptr and count increment. Next state is FULL if the new count equals DEPTH, else IDLE.
- FULL: ready_o=0 and full_o=1. Requests are ignored, not queued. Only clear_i or reset leaves FULL.
- Latency: request accepted at edge N; imem_we_o high during cycle N+2. Throughput is 1 word per 3 cycles. Back-to-back valid_i is re-accepted in the first IDLE cycle after WR.
- Opcode map: R=000000, ADDI=001001, LW=101100, SW=100100, BEQ=000110, BNE=000101, J=000111, JAL=000011.
- R encoding: {op,rs,rt,rd,shamt,funct}.
- ADDI/LW/SW/BEQ/BNE encoding: {op,rs,rt,imm}. rd, shamt, funct and target are ignored.
- J/JAL encoding: {op,target}. All other fields are ignored.
- No sign extension or arithmetic is applied: fields are packed verbatim, so the immediate is emitted as given.
- Captured fields are held stable through ENC/WR. Input changes after acceptance have no effect.
- clear_i (sync, highest priority after reset): next state IDLE; ptr=0; count=0; full=0.
  - When asserted in WR, the write in that cycle is suppressed (imem_we_o=0).
  - When asserted together with valid_i in IDLE, the request is dropped.
- Pointer never wraps. Writing past DEPTH-1 is impossible because FULL blocks acceptance.
- imem_we_o is never high in two consecutive cycles.

Test Plan:
- Reset, then send ADDI rs=1 rt=2 imm=0x0005 -> imem_we_o pulses once 2 cycles after acceptance; addr=0x0, data=0x24220005; count_o=1.
- R rs=1 rt=2 rd=3 shamt=0 funct=0x20, then J target=0x0000010 back-to-back -> words 0x00221820 @0x0 and 0x1C000010 @0x4; 3-cycle spacing; rd/imm garbage on J ignored.
- LW rs=0 rt=4 imm=0xFFFC; BEQ rs=1 rt=2 imm=0xFFFF; JAL target=3 -> 0xB004FFFC, 0x1822FFFF, 0x0C000003; SW rs=5 rt=6 imm=8 -> 0x90A60008.
- DEPTH=4: write 4 words -> full_o=1 and ready_o=0 after the 4th write; a 5th valid_i is held 10 cycles -> no imem_we_o. Then clear_i -> count_o=0; the next word goes to BASE_ADDR.
- clear_i asserted during WR -> imem_we_o stays 0 that cycle; count_o unchanged at 0. rst_i pulsed low mid-ENC -> outputs reset immediately, no write is issued.
